exibidor_sequencia: RTL and testbench
=====================================

# exibidor_sequencia

Playback unit for the memory game: on a start pulse it reads the stored sequence from the synchronous 16x4 game RAM, address 0 through the current round, and shows each word on the LEDs for a fixed on-time followed by a blank gap. It is the reader counterpart of the datapath that registers player moves and writes them to memory. It shares the RAM address bus with that datapath, drives the LED/buzzer enable and reports completion to the game control unit.

## Interface
Parameters:
- CLOCK_FREQ, 5000, clock frequency in Hz (informational; sets the defaults below)
- T_ON, CLOCK_FREQ/2, cycles each word is lit (even, ≥2)
- T_OFF, CLOCK_FREQ/4, blank cycles after each word (even, ≥2)

Ports:
- clock  in  1  system clock; one clock domain, all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- iniciar  in  1  start pulse; ignored unless idle
- rodada  in  4  index of the last word to show (inclusive)
- rapido  in  1  fast mode; halves T_ON and T_OFF
- dado_mem  in  4  RAM read data, valid one cycle after endereco changes
- endereco  out  4  RAM read address
- leds  out  4  displayed word; 0 when blank
- toca  out  1  buzzer enable, high while a word is lit
- ocupado  out  1  high in every state except OCIOSO
- fim  out  1  one-cycle pulse when playback completes
- db_estado  out  3  current state encoding, for debug

## Operation
- States: OCIOSO, ENDERECA, MOSTRA, APAGA, FIM.
- OCIOSO:
  - On iniciar=1: capture rodada into rod_reg and rapido into rap_reg, set endereco<=0, go to ENDERECA.
- ENDERECA: one cycle of RAM read latency, then go to MOSTRA with timer cleared.
- MOSTRA:
  - leds=dado_mem and toca=1.
  - Lasts t_on cycles: t_on = rap_reg ? T_ON/2 : T_ON.
  - Then go to APAGA with timer cleared.
- APAGA:
  - leds=0 and toca=0.
  - Lasts t_off cycles, with t_off halved the same way.
  - Then, if endereco==rod_reg, go to FIM.
  - Otherwise endereco<=endereco+1 and go to ENDERECA.
- FIM: fim=1 for one cycle, then OCIOSO.
- Arithmetic and ranges:
  - Timer width is $clog2(T_ON+1).
  - endereco is 4-bit and never wraps, because rod_reg≤15 bounds it.
  - rodada=0 shows exactly one word; rodada=15 shows all 16.
- Boundary conditions:
  - iniciar during ocupado=1 is ignored; rodada and rapido changes mid-playback have no effect.
  - iniciar asserted in the FIM cycle is ignored; it is accepted only in OCIOSO.
  - reset at any point: OCIOSO next cycle; endereco, leds, toca, ocupado, fim all 0.
  - The timer restarts on every state entry, so no residual count carries over.

## Timing
- Reset values: endereco=0, leds=0, toca=0, ocupado=0, fim=0, db_estado=0 (OCIOSO).
- iniciar sampled at edge k:
  - ocupado=1 from k.
  - MOSTRA entered at k+1; leds valid from k+1.
- Each word occupies 1+t_on+t_off cycles.
- fim pulses 1 cycle after the last APAGA. Total start-to-fim latency is (rodada+1)·(1+t_on+t_off)+1 cycles.
- endereco is stable for the whole ENDERECA/MOSTRA/APAGA span of a word.

## Configuration
- EXIBIDOR_BUZZER_EN:
  - Defined: toca is high during MOSTRA, as above.
  - Undefined: toca is tied 0 and the buzzer-related logic is compiled out; LED behaviour is unchanged.

## Structure
- Shared package exibidor_pkg holds:
  - state encodings: OCIOSO=0, ENDERECA=1, MOSTRA=2, APAGA=3, FIM=4
  - the 4-bit address width constant
- One sub-module is natural: the existing contador_m, reused as the on/off timer.
  - zera_s is driven on each state entry.
  - fim is compared against the selected duration by the FSM.

## Test plan
Bench parameters: T_ON=4, T_OFF=2; RAM preloaded with 1,2,4,8,…
- rodada=0, iniciar pulse -> leds=1 for 4 cycles, 0 for 2 cycles; fim 8 cycles after iniciar; endereco stays 0.
- rodada=3 -> leds sequence 1,2,4,8, each lit 4 cycles; endereco 0..3; fim at cycle 29; ocupado drops the cycle after fim.
- rodada=2, rapido=1 -> each word lit 2 cycles, gap 1 cycle; fim at cycle 13; toggling rapido mid-run changes nothing.
- Second iniciar pulse during MOSTRA of word 1 -> ignored; exactly one fim, no sequence restart.
- reset asserted during APAGA of word 2 -> next cycle OCIOSO with all outputs 0; a fresh iniciar replays from address 0.
- Build without EXIBIDOR_BUZZER_EN, rodada=1 -> toca constantly 0; leds identical to the build with the macro defined.

Source files
------------

// File: rtl/exibidor_pkg.sv
// Shared definitions for the sequence playback unit: state encodings
// and the game RAM address width.
package exibidor_pkg;

  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ENDERECA = 3'd1,
    MOSTRA   = 3'd2,
    APAGA    = 3'd3,
    FIM      = 3'd4
  } estado_t;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear, used as the on/off timer.
module contador_m #(
  parameter int M = 16,
  parameter int N = $clog2(M)
) (
  input  logic         clock,
  input  logic         zera_s,
  input  logic         conta,
  output logic [N-1:0] Q
);

  // Clear has priority; otherwise count while enabled and wrap at M-1.
  always_ff @(posedge clock) begin
    if (zera_s) begin
      Q <= '0;
    end else if (conta) begin
      if (Q == N'(M - 1)) Q <= '0;
      else                Q <= Q + N'(1);
    end
  end

endmodule

// File: rtl/exibidor_sequencia.sv
// Playback unit for the memory game: shows RAM words 0..rodada on the LEDs,
// each lit for t_on cycles followed by a t_off blank gap.
// Optional feature macro: EXIBIDOR_BUZZER_EN (drives toca while a word is lit;
// when undefined toca is tied low).
module exibidor_sequencia
  import exibidor_pkg::*;
#(
  parameter int CLOCK_FREQ = 5000,
  parameter int T_ON       = CLOCK_FREQ / 2,
  parameter int T_OFF      = CLOCK_FREQ / 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] rodada,
  input  logic              rapido,
  input  logic [3:0]        dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        leds,
  output logic              toca,
  output logic              ocupado,
  output logic              fim,
  output logic [2:0]        db_estado
);

  localparam int TW = $clog2(T_ON + 1);

  localparam logic [TW-1:0] ON_M1_FULL  = TW'(T_ON - 1);
  localparam logic [TW-1:0] ON_M1_HALF  = TW'(T_ON / 2 - 1);
  localparam logic [TW-1:0] OFF_M1_FULL = TW'(T_OFF - 1);
  localparam logic [TW-1:0] OFF_M1_HALF = TW'(T_OFF / 2 - 1);

  estado_t           estado, estado_next;
  logic [ADDR_W-1:0] rod_reg;
  logic              rap_reg;
  logic [TW-1:0]     tempo;
  logic              zera_s;
  logic              conta;
  logic [TW-1:0]     on_m1;
  logic [TW-1:0]     off_m1;
  logic              aceita;

  assign aceita = (estado == OCIOSO) && iniciar;
  assign on_m1  = rap_reg ? ON_M1_HALF  : ON_M1_FULL;
  assign off_m1 = rap_reg ? OFF_M1_HALF : OFF_M1_FULL;

  // The timer restarts on every state change so no count carries over.
  assign zera_s = reset || (estado_next != estado);
  assign conta  = (estado == MOSTRA) || (estado == APAGA);

  contador_m #(
    .M (T_ON + 1),
    .N (TW)
  ) u_timer (
    .clock  (clock),
    .zera_s (zera_s),
    .conta  (conta),
    .Q      (tempo)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= estado_next;
  end

  // Next-state logic; durations come from the mode latched at start.
  always_comb begin
    estado_next = estado;
    case (estado)
      OCIOSO:   if (iniciar) estado_next = ENDERECA;
      ENDERECA: estado_next = MOSTRA;
      MOSTRA:   if (tempo == on_m1) estado_next = APAGA;
      APAGA:    if (tempo == off_m1)
                  estado_next = (endereco == rod_reg) ? FIM : ENDERECA;
      FIM:      estado_next = OCIOSO;
      default:  estado_next = OCIOSO;
    endcase
  end

  // Read address: cleared on start, advanced when a gap ends mid-sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      endereco <= '0;
    end else if (aceita) begin
      endereco <= '0;
    end else if ((estado == APAGA) && (estado_next == ENDERECA)) begin
      endereco <= endereco + ADDR_W'(1);
    end
  end

  // Round and mode are latched only on an accepted start.
  always_ff @(posedge clock) begin
    if (aceita) begin
      rod_reg <= rodada;
      rap_reg <= rapido;
    end
  end

  // State-decoded outputs.
  always_comb begin
    leds      = (estado == MOSTRA) ? dado_mem : 4'd0;
    ocupado   = (estado != OCIOSO);
    fim       = (estado == FIM);
    db_estado = estado;
  end

`ifdef EXIBIDOR_BUZZER_EN
  assign toca = (estado == MOSTRA);
`else
  assign toca = 1'b0;
`endif

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Directed bench for exibidor_sequencia: per-cycle expected outputs are
// queued from the playback timing rules and compared as the DUT runs.
module tb_exibidor_sequencia;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
`ifdef EXIBIDOR_BUZZER_EN
  localparam logic BUZ = 1'b1;
`else
  localparam logic BUZ = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] rodada;
  logic       rapido;
  logic [3:0] dado_mem;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       toca;
  logic       ocupado;
  logic       fim;
  logic [2:0] db_estado;

  logic [3:0]  ram [16];
  logic [13:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  exibidor_sequencia #(
    .CLOCK_FREQ (5000),
    .T_ON       (T_ON),
    .T_OFF      (T_OFF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .rodada    (rodada),
    .rapido    (rapido),
    .dado_mem  (dado_mem),
    .endereco  (endereco),
    .leds      (leds),
    .toca      (toca),
    .ocupado   (ocupado),
    .fim       (fim),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  // Synchronous game RAM: data one cycle after the address.
  always @(posedge clock) dado_mem <= ram[endereco];

  function automatic logic [13:0] pack(input logic f, input logic o, input logic t,
                                       input logic [2:0] s, input logic [3:0] a,
                                       input logic [3:0] l);
    return {f, o, t, s, a, l};
  endfunction

  task automatic check(input string tag, input logic [13:0] expv);
    logic [13:0] obs;
    obs = {fim, ocupado, toca, db_estado, endereco, leds};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed {fim,ocup,toca,st,end,leds}=%b required=%b", tag, obs, expv);
    end
  endtask

  // Queue the full expected trace of one playback, starting at the
  // ENDERECA cycle of word 0 and ending with the first idle cycle.
  task automatic build_expected(input logic [3:0] rod, input logic rap);
    int t_on, t_off;
    t_on  = rap ? T_ON / 2 : T_ON;
    t_off = rap ? T_OFF / 2 : T_OFF;
    exp_q.delete();
    for (int w = 0; w <= int'(rod); w++) begin
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 3'd1, 4'(w), 4'd0));
      for (int c = 0; c < t_on; c++)
        exp_q.push_back(pack(1'b0, 1'b1, BUZ, 3'd2, 4'(w), 4'(1 << (w % 4))));
      for (int c = 0; c < t_off; c++)
        exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 3'd3, 4'(w), 4'd0));
    end
    exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 3'd4, rod, 4'd0));
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 3'd0, rod, 4'd0));
  endtask

  // poke_kind: 1 = extra iniciar with new rodada/rapido, 2 = change
  // rodada/rapido only, 3 = assert reset. Applied before the edge after
  // compared cycle poke_at. n_cycles < 0 means run the whole trace.
  task automatic run(input string name, input logic [3:0] rod, input logic rap,
                     input int n_cycles, input int poke_at, input int poke_kind);
    int n;
    build_expected(rod, rap);
    n = (n_cycles < 0) ? exp_q.size() : n_cycles;
    rodada  = rod;
    rapido  = rap;
    iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_c%0d", name, i + 1), exp_q.pop_front());
      if (i == poke_at) begin
        case (poke_kind)
          1: begin iniciar = 1'b1; rodada = 4'd0; rapido = ~rap; end
          2: begin rodada = 4'd15; rapido = ~rap; end
          3: reset = 1'b1;
          default: ;
        endcase
      end
      @(posedge clock); #1;
      iniciar = 1'b0;
    end
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 4'(1 << (i % 4));
    reset = 1'b1; iniciar = 1'b0; rodada = 4'd0; rapido = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", pack(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));
    reset = 1'b0;
    @(posedge clock); #1;

    // One word: fim on the 8th edge counting the start edge.
    run("r0", 4'd0, 1'b0, -1, -1, 0);
    // Four words, fim on the 29th edge.
    run("r3", 4'd3, 1'b0, -1, -1, 0);
    // Fast mode with rodada/rapido changed mid-run (no effect).
    run("r2fast", 4'd2, 1'b1, -1, 2, 2);
    // Second iniciar during MOSTRA of word 1 is ignored.
    run("restart", 4'd3, 1'b0, -1, 9, 1);
    // iniciar held in the FIM cycle is ignored (FIM is trace index 7).
    run("fim_ini", 4'd0, 1'b0, -1, 7, 1);
    @(posedge clock); #1;
    check("fim_ini_idle", pack(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));

    // Reset during the first APAGA cycle of word 2 (trace index 19).
    run("rst_mid", 4'd3, 1'b0, 20, 19, 3);
    check("rst_mid_after", pack(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0));
    reset = 1'b0;
    @(posedge clock); #1;
    run("replay", 4'd1, 1'b0, -1, -1, 0);

    // Last word of the RAM range.
    run("r15fast", 4'd15, 1'b1, -1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
